// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, reset vector, NOP encoding
// and the fetch state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// IF/ID output buffer: holds one fetched instruction and its PC until decode
// takes it or it is flushed.
module fetch_out_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: REQ issues a read, WAIT collects the
// response, HOLD presents it to decode. Redirects flush and retarget the PC.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            id_ready
);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_pc, pending_d;
  logic            kill, kill_d;
  logic            accept, resp, buf_load, buf_clear;

  always_comb begin
    accept    = imem_req && imem_ready && (state == FETCH_REQ);
    resp      = imem_rvalid && (state == FETCH_WAIT);
    buf_load  = resp && !kill && !redirect_valid;
    buf_clear = redirect_valid || (if_valid && id_ready);
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc_q;
    pending_d = pending_pc;
    kill_d    = kill;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
      unique case (state)
        FETCH_REQ: begin
          if (accept) begin
            state_d   = FETCH_WAIT;
            pending_d = pc_q;
            kill_d    = 1'b1;
          end
        end
        // A response landing on the redirect edge is the killed one; consume it
        // here rather than waiting for a response that will never come.
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            state_d = FETCH_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = FETCH_REQ;
      endcase
    end else begin
      unique case (state)
        FETCH_REQ: begin
          if (accept) begin
            state_d   = FETCH_WAIT;
            pending_d = pc_q;
          end
        end
        FETCH_WAIT: begin
          if (resp) begin
            if (kill) begin
              state_d = FETCH_REQ;
              kill_d  = 1'b0;
            end else begin
              state_d = FETCH_HOLD;
              pc_d    = pending_pc + XLEN'(4);
            end
          end
        end
        FETCH_HOLD: begin
          if (if_valid && id_ready) state_d = FETCH_REQ;
        end
        default: state_d = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH_REQ;
      pc_q       <= RESET_PC;
      pending_pc <= '0;
      kill       <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      state      <= state_d;
      pc_q       <= pc_d;
      pending_pc <= pending_d;
      kill       <= kill_d;
      imem_req   <= (state_d == FETCH_REQ);
    end
  end

  assign imem_addr = pc_q;

  fetch_out_reg #(
    .XLEN(XLEN)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (pending_pc),
    .load_instr(imem_rdata),
    .valid     (if_valid),
    .pc        (if_pc),
    .instr     (if_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memory responder plus a scoreboard of
// expected (pc, instr) transfers built from an independent next-PC model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_xfer = 0;
  sb_t         sb[$];
  logic [31:0] exp_pc;
  logic [31:0] resp_addr;
  int          resp_delay;
  int          resp_cnt;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .id_ready      (id_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0010_0093;
    return {addr[15:0] ^ 16'hBEEF, addr[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp_v);
    end
  endtask

  // Sample the cycle's settled state, advance one clock, then drive the responder.
  task automatic tick();
    logic acc, xfer;
    sb_t  e;
    acc  = (imem_req === 1'b1) && (imem_ready === 1'b1);
    xfer = (if_valid === 1'b1) && (id_ready === 1'b1);
    if (xfer) begin
      n_xfer++;
      chk1("xfer_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("xfer_pc", if_pc, e.pc);
        chk("xfer_instr", if_instr, e.instr);
      end
    end
    if (acc) begin
      chk("req_addr", imem_addr, exp_pc);
      resp_cnt  = resp_delay;
      resp_addr = exp_pc;
    end
    if (redirect_valid) begin
      sb.delete();
      exp_pc = redirect_pc & ~32'd3;
    end else if (acc) begin
      sb.push_back('{exp_pc, mem_data(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
    if (!rst) begin
      sb.delete();
      exp_pc = RESET_PC;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(resp_addr);
      end
    end
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    exp_pc = RESET_PC; resp_delay = 1; resp_cnt = 0; resp_addr = '0;

    // Reset state
    tick(); tick();
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, NOP);

    // First fetch after release, zero wait states
    rst = 1'b1;
    tick();
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, RESET_PC);
    imem_ready = 1'b1; id_ready = 1'b1;
    tick();
    chk1("wait_no_req", imem_req, 1'b0);
    tick();
    chk1("first_if_valid", if_valid, 1'b1);
    chk("first_if_pc", if_pc, 32'h0);
    chk("first_if_instr", if_instr, 32'h0010_0093);
    tick();
    chk1("second_req", imem_req, 1'b1);
    chk("second_addr", imem_addr, 32'h4);

    // Decode stall holds the buffer and blocks new requests
    id_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk1("stall_valid", if_valid, 1'b1);
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_instr", if_instr, mem_data(32'h4));
      chk1("stall_no_req", imem_req, 1'b0);
      tick();
    end
    id_ready = 1'b1;
    tick();
    chk1("post_stall_req", imem_req, 1'b1);
    chk("post_stall_addr", imem_addr, 32'h8);

    // Redirect coincident with request acceptance
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk1("rdacc_wait", imem_req, 1'b0);
    tick();
    chk1("rdacc_dropped", if_valid, 1'b0);
    chk1("rdacc_req", imem_req, 1'b1);
    chk("rdacc_addr", imem_addr, 32'h40);
    tick(); tick();
    chk("rdacc_if_pc", if_pc, 32'h40);
    tick();
    chk("rdacc_next_addr", imem_addr, 32'h44);

    // Redirect while waiting, slow response is killed
    resp_delay = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk1("kill_wait_req", imem_req, 1'b0);
    tick();
    chk1("kill_still_wait", imem_req, 1'b0);
    tick();
    chk1("kill_dropped", if_valid, 1'b0);
    chk1("kill_req", imem_req, 1'b1);
    chk("kill_addr", imem_addr, 32'h100);
    resp_delay = 1;
    tick(); tick();
    chk("kill_if_pc", if_pc, 32'h100);
    tick();
    chk("kill_next_addr", imem_addr, 32'h104);

    // PC wrap at the top of the address space
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk1("wrap_req", imem_req, 1'b1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    tick(); tick();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Asynchronous reset mid-WAIT with a stray late response
    resp_delay = 3;
    tick();
    #2 rst = 1'b0;
    #1;
    chk1("async_rst_if_valid", if_valid, 1'b0);
    chk1("async_rst_req", imem_req, 1'b0);
    imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk1("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, RESET_PC);
    chk1("rel_if_valid", if_valid, 1'b0);
    tick();
    chk1("stray_ignored", if_valid, 1'b0);
    chk1("stray_req", imem_req, 1'b1);
    chk("stray_addr", imem_addr, RESET_PC);
    resp_delay = 1; imem_ready = 1'b1;
    tick(); tick();
    chk("rel_if_instr", if_instr, 32'h0010_0093);
    tick();
    chk("rel_next_addr", imem_addr, 32'h4);

    imem_ready = 1'b0;
    tick();
    chk("sb_drained", sb.size(), 32'd0);
    chk("xfer_count", n_xfer, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the address/instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  SHALL flag a taken branch/jump from the next-PC select path.
REQ-006 redirect_pc  input  XLEN  SHALL be the target address, valid when redirect_valid=1.
REQ-007 imem_req  output  1  SHALL flag a valid instruction-memory read request.
REQ-008 imem_addr  output  XLEN  SHALL be the request address.
REQ-009 imem_ready  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-010 imem_rvalid  input  1  SHALL flag returned read data.
REQ-011 imem_rdata  input  32  SHALL be the returned instruction.
REQ-012 if_valid  output  1  SHALL flag a valid fetched instruction to the IF/ID register.
REQ-013 if_pc  output  XLEN  SHALL be the PC of the instruction on if_instr.
REQ-014 if_instr  output  32  SHALL be the fetched instruction.
REQ-015 id_ready  input  1  SHALL indicate that decode accepts the output this cycle (stall folded in upstream).

Function
REQ-016 The state machine SHALL have the states REQ, WAIT and HOLD, with at most one memory request outstanding.
REQ-017 In REQ: imem_req=1 and imem_addr=pc_q. When imem_ready=1, the block SHALL latch pending_pc=pc_q and move to WAIT.
REQ-018 In WAIT: imem_req=0. When imem_rvalid=1 and the request is not killed, the block SHALL load the output buffer (if_valid=1, if_pc=pending_pc, if_instr=imem_rdata), set pc_q=pending_pc+4 and move to HOLD.
REQ-019 In HOLD: when if_valid=1 and id_ready=1, the block SHALL clear if_valid and move to REQ.
REQ-020 A transfer SHALL occur only on if_valid=1 and id_ready=1; if_pc and if_instr SHALL stay stable while if_valid=1 and id_ready=0.
REQ-021 PC increment SHALL be modulo 2^XLEN; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-022 redirect_valid=1 SHALL take priority over every other event in every state. Effects on the same edge:
  - pc_q=redirect_pc with bits [1:0] forced to 0
  - if_valid cleared
  - next state REQ, except from WAIT
REQ-023 Redirect in WAIT SHALL set a kill flag and remain in WAIT. The matching rvalid response SHALL be dropped (no buffer load, no pc_q update), the kill flag cleared, and the next state SHALL be REQ.
REQ-024 Redirect in REQ with imem_ready=1 in the same cycle SHALL treat the request as accepted and killed: next state WAIT, kill flag set, pc_q=redirect_pc.
REQ-025 imem_rvalid in REQ or HOLD SHALL be ignored.
REQ-026 Latency: the first cycle after reset release SHALL present imem_req=1 with imem_addr=RESET_PC. With imem_ready=1 and rvalid one cycle later, if_valid SHALL assert 2 cycles after request acceptance.
REQ-027 Zero-wait-state throughput SHALL be one instruction per 3 cycles; no prefetch beyond one request.

Reset
REQ-028 While rst=0, the block SHALL hold:
  - state=REQ, pc_q=RESET_PC, pending_pc=0, kill=0
  - if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP)
  - imem_req=0
REQ-029 Reset asserted mid-transaction SHALL abandon the outstanding request; a late rvalid arriving after release while in REQ SHALL be ignored per REQ-025.

Structure
REQ-030 XLEN, RESET_PC default, the NOP encoding and the fetch state enum SHALL live in the shared package riscv_pkg.
REQ-031 The output buffer (valid/pc/instr with load and clear) SHALL be a sub-module named fetch_out_reg; all other logic SHALL reside in fetch_unit.

Verification
REQ-032 Reset release, imem_ready=1, rvalid one cycle after accept, rdata=32'h0010_0093, id_ready=1 -> imem_addr=0, then if_valid=1, if_pc=0, if_instr=32'h0010_0093; next imem_addr=4.
REQ-033 id_ready=0 for 5 cycles while if_valid=1 -> if_pc/if_instr held constant, imem_req=0, no new request; id_ready=1 -> transfer, then REQ at pc+4.
REQ-034 redirect_valid=1, redirect_pc=32'h0000_0102, while in WAIT -> kill set; the returning rdata is never presented; next imem_addr=32'h0000_0100.
REQ-035 redirect coincident with imem_ready=1 in REQ (pc=8, target=32'h40) -> response for address 8 is dropped; next request address is 32'h40.
REQ-036 pc_q=32'hFFFF_FFFC fetch completes -> if_pc=32'hFFFF_FFFC; next imem_addr=0.
REQ-037 rst=0 asserted asynchronously mid-WAIT -> if_valid=0 and imem_req=0 immediately; after release, imem_addr=RESET_PC, and a stray rvalid is ignored.
